// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAckAddr,
    StWrByte,
    StAckWr,
    StRdByte,
    StAckRd
  } i2c_state_t;

  typedef enum logic [1:0] {
    EvNone,
    EvStart,
    EvStop
  } bus_ev_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int unsigned BYTES_PER_WORD = 2;

  // STOP wins if both are somehow flagged together.
  function automatic bus_ev_t bus_event(logic start_det, logic stop_det);
    if (stop_det) return EvStop;
    if (start_det) return EvStart;
    return EvNone;
  endfunction

endpackage

// File: rtl/i2c_target_resp_if.sv
// I2C wire-level signals between a controller and the target responder.
interface i2c_target_resp_if;
  logic SCL;
  logic SDA_IN;
  logic SDA_OUT;
  logic SDA_OE;

  modport master (output SCL, output SDA_IN, input SDA_OUT, input SDA_OE);
  modport slave  (input SCL, input SDA_IN, output SDA_OUT, output SDA_OE);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s;

  // Reset to the idle-bus level so release of reset never looks like an event.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target_resp.sv
// I2C target: 7-bit address match, 16-bit write/read word transfers.
// Define I2C_GENERAL_CALL_EN to also accept general-call (7'h00) writes.
module i2c_target_resp
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [6:0]  TGT_ADDR_RST = 7'h00
) (
  input  logic               CLK,
  input  logic               RESET,
  i2c_target_resp_if.slave   bus,
  input  logic [6:0]         I2C_ADDR,
  input  logic [15:0]        RD_DATA,
  output logic [15:0]        WR_DATA,
  output logic               WR_STB,
  output logic               BUSY
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .scl       (bus.SCL),
    .sda       (bus.SDA_IN),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_t  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_idx_q, byte_idx_d;
  logic        phase_q, phase_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  addr_sh_q, addr_sh_d;
  logic [6:0]  tgt_addr_q, tgt_addr_d;
  logic [15:0] wr_shadow_q, wr_shadow_d;
  logic [15:0] rd_word_q, rd_word_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_stb_q, wr_stb_d;
  logic        sda_oe_q, sda_oe_d;
  logic        sda_bit_q, sda_bit_d;
  logic        addr_hit, gc_hit;
  bus_ev_t     ev;

  always_comb begin
    addr_hit = (addr_sh_q == tgt_addr_q);
`ifdef I2C_GENERAL_CALL_EN
    gc_hit   = (addr_sh_q == 7'h00) && (sda_s == 1'b0);
`else
    gc_hit   = 1'b0;
`endif
  end

  assign ev = bus_event(start_det, stop_det);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    phase_d     = phase_q;
    rnw_d       = rnw_q;
    addr_sh_d   = addr_sh_q;
    tgt_addr_d  = tgt_addr_q;
    wr_shadow_d = wr_shadow_q;
    rd_word_d   = rd_word_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = 1'b0;
    sda_oe_d    = sda_oe_q;
    sda_bit_d   = sda_bit_q;

    if (ev == EvStop) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      byte_idx_d = 1'b0;
      phase_d    = 1'b0;
      sda_oe_d   = 1'b0;
      sda_bit_d  = NACK;
    end else if (ev == EvStart) begin
      state_d    = StAddr;
      bit_cnt_d  = '0;
      byte_idx_d = 1'b0;
      phase_d    = 1'b0;
      sda_oe_d   = 1'b0;
      sda_bit_d  = NACK;
      tgt_addr_d = I2C_ADDR;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            addr_sh_d = {addr_sh_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // 8th rise: addr_sh_q holds the address, sda_s is RNW.
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              rnw_d     = sda_s;
              state_d   = (addr_hit || gc_hit) ? StAckAddr : StIdle;
            end
          end
        end
        StAckAddr: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d   = 1'b1;
              sda_oe_d  = 1'b1;
              sda_bit_d = ACK;
            end else begin
              phase_d    = 1'b0;
              bit_cnt_d  = '0;
              byte_idx_d = 1'b0;
              if (rnw_q) begin
                rd_word_d = RD_DATA;
                sda_oe_d  = 1'b1;
                sda_bit_d = RD_DATA[15];
                state_d   = StRdByte;
              end else begin
                sda_oe_d  = 1'b0;
                sda_bit_d = NACK;
                state_d   = StWrByte;
              end
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            wr_shadow_d = {wr_shadow_q[14:0], sda_s};
            bit_cnt_d   = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = StAckWr;
            end
          end
        end
        StAckWr: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d   = 1'b1;
              sda_oe_d  = 1'b1;
              sda_bit_d = ACK;
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              sda_bit_d = NACK;
              state_d   = StWrByte;
              if (byte_idx_q == 1'(BYTES_PER_WORD - 1)) begin
                wr_data_d  = wr_shadow_q;
                wr_stb_d   = 1'b1;
                byte_idx_d = 1'b0;
              end else begin
                byte_idx_d = 1'b1;
              end
            end
          end
        end
        StRdByte: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              sda_bit_d = NACK;
              state_d   = StAckRd;
            end else begin
              // Word bit index = 15 - (8*byte_idx + bits already sent).
              sda_oe_d  = 1'b1;
              sda_bit_d = rd_word_q[{~byte_idx_q, ~bit_cnt_q[2:0]}];
            end
          end
        end
        StAckRd: begin
          if (scl_rise) begin
            if (sda_s == ACK) begin
              byte_idx_d = ~byte_idx_q;
              state_d    = StRdByte;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_idx_q  <= 1'b0;
      phase_q     <= 1'b0;
      rnw_q       <= 1'b0;
      addr_sh_q   <= '0;
      tgt_addr_q  <= TGT_ADDR_RST;
      wr_shadow_q <= '0;
      rd_word_q   <= '0;
      wr_data_q   <= '0;
      wr_stb_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      sda_bit_q   <= NACK;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      phase_q     <= phase_d;
      rnw_q       <= rnw_d;
      addr_sh_q   <= addr_sh_d;
      tgt_addr_q  <= tgt_addr_d;
      wr_shadow_q <= wr_shadow_d;
      rd_word_q   <= rd_word_d;
      wr_data_q   <= wr_data_d;
      wr_stb_q    <= wr_stb_d;
      sda_oe_q    <= sda_oe_d;
      sda_bit_q   <= sda_bit_d;
    end
  end

  assign bus.SDA_OE  = sda_oe_q;
  assign bus.SDA_OUT = sda_oe_q ? sda_bit_q : 1'b1;
  assign WR_DATA     = wr_data_q;
  assign WR_STB      = wr_stb_q;
  assign BUSY        = (state_q != StIdle);

endmodule
